ram_result_scanner: RTL and testbench

Downstream consumer of the sequence-generation controller. Once the controller has filled the result RAM (entries 0..DEPTH-1, each entry the sum of the two before it), this block walks the RAM in address order and presents each value to the board display for a fixed hold time. While walking, it checks the recurrence `mem[n] == mem[n-1] + mem[n-2]` (mod 2^DATA_W) for n ≥ 2 and latches the first failing address.

---
 rtl/ram_result_scanner.sv | 162 ++++++++++++++++
 tb/tb_ram_result_scanner.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ram_result_scanner.sv
// Walks the result RAM in address order and shows each word for HOLD_CYCLES cycles.
// While walking, it checks the additive recurrence and latches the first failing address.
module ram_result_scanner #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 32,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [5:0]        ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] disp_data,
  output logic [5:0]        disp_addr,
  output logic              disp_valid,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [5:0]        err_addr
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [5:0]       LAST_IDX  = 6'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_HOLD    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] prev1_q, prev1_d;
  logic [DATA_W-1:0] prev2_q, prev2_d;
  logic [5:0]        ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic [5:0]        disp_addr_q, disp_addr_d;
  logic              disp_valid_q, disp_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [5:0]        err_addr_q, err_addr_d;
  logic [DATA_W-1:0] sum_s;

  // Carry out is dropped so the check follows the RAM's wrap-around arithmetic.
  assign sum_s = prev1_q + prev2_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    prev1_d      = prev1_q;
    prev2_d      = prev2_q;
    ram_addr_d   = ram_addr_q;
    disp_data_d  = disp_data_q;
    disp_addr_d  = disp_addr_q;
    disp_valid_d = disp_valid_q;
    err_d        = err_q;
    err_addr_d   = err_addr_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          idx_d        = 6'd0;
          err_d        = 1'b0;
          err_addr_d   = 6'd0;
          disp_valid_d = 1'b0;
          ram_addr_d   = 6'd0;
          state_d      = S_ISSUE;
        end else begin
          state_d = state_q;
        end
      end
      S_ISSUE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        disp_data_d  = ram_dout;
        disp_addr_d  = idx_q;
        disp_valid_d = 1'b1;
        prev2_d      = prev1_q;
        prev1_d      = ram_dout;
        if ((idx_q >= 6'd2) && (ram_dout != sum_s) && !err_q) begin
          err_d      = 1'b1;
          err_addr_d = idx_q;
        end else begin
          err_d      = err_q;
          err_addr_d = err_addr_q;
        end
        cnt_d   = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d      = idx_q + 6'd1;
            ram_addr_d = idx_q + 6'd1;
            state_d    = S_ISSUE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_ISSUE) || (state_d == S_CAPTURE) || (state_d == S_HOLD);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= 6'd0;
      cnt_q        <= '0;
      prev1_q      <= '0;
      prev2_q      <= '0;
      ram_addr_q   <= 6'd0;
      disp_data_q  <= '0;
      disp_addr_q  <= 6'd0;
      disp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_addr_q   <= 6'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      prev1_q      <= prev1_d;
      prev2_q      <= prev2_d;
      ram_addr_q   <= ram_addr_d;
      disp_data_q  <= disp_data_d;
      disp_addr_q  <= disp_addr_d;
      disp_valid_q <= disp_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_addr_q   <= err_addr_d;
    end
  end

  assign ram_addr   = ram_addr_q;
  assign disp_data  = disp_data_q;
  assign disp_addr  = disp_addr_q;
  assign disp_valid = disp_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_ram_result_scanner.sv
// Directed plus randomized bench for ram_result_scanner with a 1-cycle-latency RAM model.
// Expected display/error timeline is computed from the scan rules, cycle by cycle.
module tb_ram_result_scanner;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int HOLD   = 4;
  localparam int PER    = HOLD + 2;
  localparam int TOTAL  = DEPTH * PER;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [5:0]        ram_addr;
  logic [DATA_W-1:0] ram_dout = '0;
  logic [DATA_W-1:0] disp_data;
  logic [5:0]        disp_addr;
  logic              disp_valid;
  logic              busy;
  logic              done;
  logic              err;
  logic [5:0]        err_addr;

  logic [DATA_W-1:0] mem [0:63];
  int n_checks = 0;
  int n_fail   = 0;

  ram_result_scanner #(.DATA_W(DATA_W), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ram_addr(ram_addr), .ram_dout(ram_dout),
    .disp_data(disp_data), .disp_addr(disp_addr), .disp_valid(disp_valid),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_dout <= mem[ram_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    mem[0] = a;
    mem[1] = b;
    for (int n = 2; n < 64; n++) mem[n] = mem[n-1] + mem[n-2];
  endtask

  function automatic int first_err();
    logic [DATA_W-1:0] s;
    for (int n = 2; n < DEPTH; n++) begin
      s = mem[n-1] + mem[n-2];
      if (mem[n] !== s) return n;
    end
    return -1;
  endfunction

  task automatic chk_zero(input string tag);
    chk(tag, {ram_addr, disp_data, disp_addr, disp_valid, busy, done, err, err_addr}, 64'd0);
  endtask

  // One scan started now; cycle 1 is the ISSUE of entry 0. Optional extra start pulse or reset.
  task automatic scan(input int extra_start, input int rst_at);
    int fe;
    fe = first_err();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= TOTAL + 1; cyc++) begin
      int k;
      int ph;
      int sh;
      logic exp_err;
      k  = (cyc - 1) / PER;
      ph = (cyc - 1) % PER;
      if (cyc == TOTAL + 1) begin
        sh = DEPTH - 1;
        chk("busy_done_end", {busy, done}, 2'b01);
      end else begin
        sh = (ph >= 2) ? k : k - 1;
        chk("busy_done_scan", {busy, done}, 2'b10);
        if (ph == 0) chk("ram_addr", ram_addr, k);
      end
      if (sh < 0) begin
        chk("valid_low", disp_valid, 1'b0);
        chk("err_clear", {err, err_addr}, 7'd0);
      end else begin
        exp_err = (fe >= 0) && (fe <= sh);
        chk("valid", disp_valid, 1'b1);
        chk("disp_addr", disp_addr, sh);
        chk("disp_data", disp_data, mem[sh]);
        chk("err", err, exp_err);
        chk("err_addr", err_addr, exp_err ? fe : 0);
      end
      if (cyc == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_zero("reset_mid");
        @(posedge clk); #1;
        chk_zero("idle_after_reset");
        return;
      end
      if (cyc == extra_start) start = 1'b1;
      if (cyc <= TOTAL) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
  endtask

  initial begin
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    int pos;
    fill(32'd1, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero("reset_state");

    // clean Fibonacci, done timing covered inside scan
    scan(0, 0);
    chk("fib_last", disp_data, 32'd2178309);

    // restart from DONE with a start pulse mid-scan that must be ignored
    scan(50, 0);

    // injected errors: first one at 10 must win
    mem[10] = 32'd90;
    mem[20] = 32'd0;
    scan(0, 0);
    chk("err_addr_done", {err, err_addr}, {1'b1, 6'd10});

    // clean rescan clears the sticky error
    fill(32'd1, 32'd1);
    scan(0, 0);

    // reset during HOLD of entry 7 after an error at 3 was flagged
    mem[3] = 32'd7;
    scan(0, 7 * PER + 3);
    fill(32'd1, 32'd1);
    scan(0, 0);
    chk("no_stale_err", {err, err_addr}, 7'd0);

    // wrap-around in the check adder
    fill(32'hFFFF_FF00, 32'h0000_0300);
    scan(0, 0);
    chk("wrap_no_err", err, 1'b0);

    // randomized contents with an optional corruption
    for (int it = 0; it < 4; it++) begin
      a = $urandom;
      b = $urandom;
      fill(a, b);
      if ($urandom_range(1, 0) == 1) begin
        pos = $urandom_range(DEPTH - 1, 2);
        mem[pos] = mem[pos] + ($urandom | 32'd1);
      end
      scan(0, 0);
    end

    // simultaneous rst and start from DONE: reset wins
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    chk_zero("rst_start_same");
    @(posedge clk); #1;
    chk_zero("rst_start_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
